// File: rtl/ans_freq_table_pkg.sv
// Shared definitions for the ANS frequency-table stage.
// Provides default widths (SYM_WIDTH, CNT_WIDTH, STATE_WIDTH), the symbol count
// and the FSM state encoding.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

package ans_freq_table_pkg;

   localparam int unsigned NUM_SYMS = 2 ** `SYM_WIDTH;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StLoad = 2'b01,
      StRun  = 2'b10
   } ans_state_e;

endpackage

// File: rtl/ans_skid_buf.sv
// Generic 2-entry valid/ready buffer.
// o_rdy is registered, so there is no combinational path from i_rdy to o_rdy.
// With two entries it sustains one beat per cycle.
module ans_skid_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ena,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_vld,
   output logic             o_rdy,
   output logic [WIDTH-1:0] o_data,
   output logic             o_vld,
   input  logic             i_rdy
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             r_rdy;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_count_nxt;

   assign w_push      = i_vld && r_rdy;
   assign w_pop       = (r_count != 2'd0) && i_rdy;
   assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign o_rdy  = r_rdy;
   assign o_vld  = (r_count != 2'd0);
   assign o_data = r_mem[r_rd_ptr];

   // FIFO storage, pointers and the registered not-full flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_rdy    <= 1'b1;
      end else if (i_ena) begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= w_count_nxt;
         r_rdy   <= (w_count_nxt != 2'd2);
      end
   end

endmodule

// File: rtl/ans_freq_table.sv
// Per-symbol frequency table feeding the ANS encoder.
// It loads the counts once per stream and builds the cumulative counts as they arrive.
// At run time it turns raw symbols into {count, cumulative, total} beats.
// Optional macro ANS_FREQ_SKID_EN adds a 2-entry output skid buffer and a registered sym_rdy.
// When the macro is undefined there is a single output register.
`ifndef SYM_WIDTH
`define SYM_WIDTH 4
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

module ans_freq_table
   import ans_freq_table_pkg::*;
#(
   parameter int unsigned SYM_WIDTH   = `SYM_WIDTH,
   parameter int unsigned CNT_WIDTH   = `CNT_WIDTH,
   parameter int unsigned STATE_WIDTH = `STATE_WIDTH
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_ena,
   input  logic                          i_ld_start,
   input  logic [CNT_WIDTH-1:0]          i_ld_count,
   input  logic                          i_ld_vld,
   output logic                          o_ld_rdy,
   input  logic [SYM_WIDTH-1:0]          i_sym_in,
   input  logic                          i_sym_vld,
   output logic                          o_sym_rdy,
   output logic [CNT_WIDTH-1:0]          o_s_count,
   output logic [SYM_WIDTH+CNT_WIDTH-1:0] o_s_cumulative,
   output logic [STATE_WIDTH-1:0]        o_total_count,
   output logic                          o_out_vld,
   input  logic                          i_out_rdy,
   output logic                          o_err
);

   localparam int unsigned NumSyms  = 2 ** SYM_WIDTH;
   localparam int unsigned CumWidth = SYM_WIDTH + CNT_WIDTH;

   ans_state_e           r_state;
   logic [SYM_WIDTH-1:0] r_idx;
   logic [STATE_WIDTH:0] r_sum;
   logic [STATE_WIDTH-1:0] r_total;
   logic                 r_err;
   logic                 r_ld_rdy;
   logic [CNT_WIDTH-1:0] r_cnt [NumSyms];
   logic [CumWidth-1:0]  r_cum [NumSyms];

   logic                 w_restart;
   logic                 w_ld_wr;
   logic                 w_sym_fire;
   logic                 w_sym_zero;
   logic                 w_beat_push;
   logic [STATE_WIDTH:0] w_sum_nxt;
   logic [CNT_WIDTH-1:0] w_lk_count;
   logic [CumWidth-1:0]  w_lk_cum;

   // A restart from RUN is only safe once the last beat has left
   assign w_restart   = i_ld_start && ((r_state != StRun) || !o_out_vld);
   assign w_ld_wr     = i_ld_vld && r_ld_rdy && !i_ld_start;
   assign w_sym_fire  = i_sym_vld && o_sym_rdy;
   assign w_lk_count  = r_cnt[i_sym_in];
   assign w_lk_cum    = r_cum[i_sym_in];
   assign w_sym_zero  = (w_lk_count == '0);
   assign w_beat_push = w_sym_fire && !w_sym_zero;
   // Once the overflow bit is set the running sum sticks there
   assign w_sum_nxt   = r_sum[STATE_WIDTH] ? r_sum
                                           : r_sum + (STATE_WIDTH + 1)'(i_ld_count);

   assign o_ld_rdy      = r_ld_rdy;
   assign o_total_count = r_total;
   assign o_err         = r_err;

   // Control FSM: load sequencing, running sum, total and sticky error
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_idx    <= '0;
         r_sum    <= '0;
         r_total  <= '0;
         r_err    <= 1'b0;
         r_ld_rdy <= 1'b0;
      end else if (i_ena) begin
         if (w_restart) begin
            r_state  <= StLoad;
            r_idx    <= '0;
            r_sum    <= '0;
            r_total  <= '0;
            r_err    <= 1'b0;
            r_ld_rdy <= 1'b1;
         end else begin
            case (r_state)
               StLoad: begin
                  if (w_ld_wr) begin
                     r_sum <= w_sum_nxt;
                     r_idx <= r_idx + SYM_WIDTH'(1);
                     if (w_sum_nxt[STATE_WIDTH]) begin
                        r_err <= 1'b1;
                     end
                     if (r_idx == SYM_WIDTH'(NumSyms - 1)) begin
                        r_total  <= w_sum_nxt[STATE_WIDTH] ? '1 : w_sum_nxt[STATE_WIDTH-1:0];
                        r_ld_rdy <= 1'b0;
                        r_state  <= StRun;
                     end
                  end
               end
               StRun: begin
                  // A zero-count symbol is consumed but produces no beat
                  if (w_sym_fire && w_sym_zero) begin
                     r_err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Table storage: count and cumulative offset written once per load beat
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_ena && w_ld_wr) begin
         r_cnt[r_idx] <= i_ld_count;
         r_cum[r_idx] <= CumWidth'(r_sum);
      end
   end

`ifdef ANS_FREQ_SKID_EN
   logic                          w_skid_rdy;
   logic [CNT_WIDTH+CumWidth-1:0] w_skid_data;

   assign o_sym_rdy      = (r_state == StRun) && w_skid_rdy;
   assign o_s_count      = w_skid_data[CNT_WIDTH+CumWidth-1:CumWidth];
   assign o_s_cumulative = w_skid_data[CumWidth-1:0];

   ans_skid_buf #(
      .WIDTH(CNT_WIDTH + CumWidth)
   ) u_skid (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_ena  (i_ena),
      .i_data ({w_lk_count, w_lk_cum}),
      .i_vld  (w_beat_push),
      .o_rdy  (w_skid_rdy),
      .o_data (w_skid_data),
      .o_vld  (o_out_vld),
      .i_rdy  (i_out_rdy)
   );
`else
   logic                 r_out_vld;
   logic [CNT_WIDTH-1:0] r_s_count;
   logic [CumWidth-1:0]  r_s_cum;

   assign o_sym_rdy      = (r_state == StRun) && (!r_out_vld || i_out_rdy);
   assign o_out_vld      = r_out_vld;
   assign o_s_count      = r_s_count;
   assign o_s_cumulative = r_s_cum;

   // Single output register: a new beat replaces a draining one with no bubble
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_vld <= 1'b0;
         r_s_count <= '0;
         r_s_cum   <= '0;
      end else if (i_ena) begin
         if (w_beat_push) begin
            r_out_vld <= 1'b1;
            r_s_count <= w_lk_count;
            r_s_cum   <= w_lk_cum;
         end else if (i_out_rdy) begin
            r_out_vld <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ans_freq_table.sv
// Directed self-checking bench for ans_freq_table.
// u_dut uses the default widths. u_dut8 uses STATE_WIDTH=8 to exercise total overflow.
module tb_ans_freq_table;
   import ans_freq_table_pkg::*;

`ifdef ANS_FREQ_SKID_EN
   localparam int ExpStall = 2;
`else
   localparam int ExpStall = 1;
`endif

   logic        clk = 1'b0;
   logic        rst, ena, ld_start, ld_vld, sym_vld, out_rdy;
   logic [7:0]  ld_count;
   logic [3:0]  sym_in;
   logic        ld_rdy, sym_rdy, out_vld, err;
   logic [7:0]  s_count;
   logic [11:0] s_cum;
   logic [15:0] total;
   logic        ld_rdy8, sym_rdy8, out_vld8, err8;
   logic [7:0]  s_count8;
   logic [11:0] s_cum8;
   logic [7:0]  total8;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  tbl [NUM_SYMS];

   logic [3:0]  sb_q [$];
   int          next_i, got;
   logic        prev_hold, acc, drn;
   logic [11:0] prev_cum;

   always #5 clk = ~clk;

   ans_freq_table u_dut (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ld_start(ld_start), .i_ld_count(ld_count),
      .i_ld_vld(ld_vld), .o_ld_rdy(ld_rdy), .i_sym_in(sym_in), .i_sym_vld(sym_vld),
      .o_sym_rdy(sym_rdy), .o_s_count(s_count), .o_s_cumulative(s_cum),
      .o_total_count(total), .o_out_vld(out_vld), .i_out_rdy(out_rdy), .o_err(err)
   );

   ans_freq_table #(.STATE_WIDTH(8)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ld_start(ld_start), .i_ld_count(ld_count),
      .i_ld_vld(ld_vld), .o_ld_rdy(ld_rdy8), .i_sym_in(sym_in), .i_sym_vld(sym_vld),
      .o_sym_rdy(sym_rdy8), .o_s_count(s_count8), .o_s_cumulative(s_cum8),
      .o_total_count(total8), .o_out_vld(out_vld8), .i_out_rdy(out_rdy), .o_err(err8)
   );

   task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_table(input int n_beats);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < n_beats; i++) begin
         ld_vld   = 1'b1;
         ld_count = tbl[i];
         tick();
      end
      ld_vld = 1'b0;
   endtask

   task automatic send_sym(input logic [3:0] s);
      logic fired;
      fired   = 1'b0;
      sym_vld = 1'b1;
      sym_in  = s;
      #1;
      for (int k = 0; k < 20 && !fired; k++) begin
         fired = sym_rdy;
         tick();
      end
      sym_vld = 1'b0;
      if (!fired) check("send_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; ld_start = 1'b0; ld_vld = 1'b0; ld_count = '0;
      sym_vld = 1'b0; sym_in = '0; out_rdy = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_ld_rdy", ld_rdy, 0);
      check("rst_sym_rdy", sym_rdy, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_err", err, 0);
      check("rst_s_count", s_count, 0);
      check("rst_s_cum", s_cum, 0);
      check("rst_total", total, 0);

      // All-ones table
      for (int i = 0; i < NUM_SYMS; i++) tbl[i] = 8'd1;
      load_table(NUM_SYMS);
      check("ones_total", total, 16);
      check("ones_ld_rdy", ld_rdy, 0);
      check("ones_err", err, 0);
      check("ones_pre_vld", out_vld, 0);
      send_sym(4'd5);
      check("ones_vld", out_vld, 1);
      check("ones_count", s_count, 1);
      check("ones_cum", s_cum, 5);
      tick();
      check("ones_drain", out_vld, 0);

      // Zero-count symbol 0, weight 8 on symbol 1
      tbl[0] = 8'd0;
      tbl[1] = 8'd8;
      load_table(NUM_SYMS);
      check("zero_total", total, 22);
      send_sym(4'd0);
      check("zero_err", err, 1);
      check("zero_no_beat", out_vld, 0);
      send_sym(4'd3);
      check("s3_vld", out_vld, 1);
      check("s3_count", s_count, 1);
      check("s3_cum", s_cum, 9);
      tick();

      // Back-pressure: 5 stalled cycles with symbols 1..6 offered continuously
      for (int i = 0; i < NUM_SYMS; i++) tbl[i] = 8'd1;
      load_table(NUM_SYMS);
      sb_q.delete();
      next_i = 0; got = 0; prev_hold = 1'b0; prev_cum = '0;
      sym_vld = 1'b1;
      sym_in  = 4'd1;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         out_rdy = (cyc >= 5);
         #1;
         if (cyc == 5) check("stall_accepts", next_i, ExpStall);
         if (prev_hold) check("hold_cum", s_cum, {20'd0, prev_cum});
         acc = sym_vld && sym_rdy;
         drn = out_vld && out_rdy;
         if (drn) begin
            if (sb_q.size() == 0) begin
               check("spurious_beat", 1, 0);
            end else begin
               check("order_cum", s_cum, {8'd0, sb_q.pop_front()});
               check("order_count", s_count, 1);
            end
            got++;
         end
         prev_hold = out_vld && !out_rdy;
         prev_cum  = s_cum;
         if (acc) begin
            sb_q.push_back(sym_in);
            next_i++;
         end
         tick();
         if (acc) begin
            if (next_i == 6) sym_vld = 1'b0;
            else sym_in = 4'(next_i + 1);
         end
      end
      sym_vld = 1'b0;
      out_rdy = 1'b1;
      check("stream_done", got, 6);

      // Overflow on the 8-bit total instance
      for (int i = 0; i < NUM_SYMS; i++) tbl[i] = 8'hFF;
      load_table(NUM_SYMS);
      check("ovf8_err", err8, 1);
      check("ovf8_total", total8, 8'hFF);
      check("ovf16_err", err, 0);
      check("ovf16_total", total, 16'h0FF0);

      // Reset in the middle of a load at idx 7
      load_table(7);
      check("mid_ld_rdy", ld_rdy, 1);
      check("mid_err8", err8, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_ld_rdy", ld_rdy, 0);
      check("rst_mid_err8", err8, 0);
      check("rst_mid_sym_rdy", sym_rdy, 0);
      check("rst_mid_total", total, 0);
      for (int i = 0; i < NUM_SYMS; i++) tbl[i] = 8'd1;
      load_table(NUM_SYMS);
      check("reload_total", total, 16);
      send_sym(4'd5);
      check("reload_cum", s_cum, 5);
      tick();

      // Clock enable low mid-RUN
      send_sym(4'd7);
      check("ena_pre_vld", out_vld, 1);
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ena_hold_vld", out_vld, 1);
         check("ena_hold_cum", s_cum, 7);
      end
      ena = 1'b1;
      tick();
      check("ena_drain", out_vld, 0);
      send_sym(4'd9);
      check("ena_resume_vld", out_vld, 1);
      check("ena_resume_cum", s_cum, 9);
      check("run_total", total, 16);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
